alu_pipe: RTL and testbench

- Parametrised, elastic pipelined ALU and the successor of the fixed two-register ALU timing wrapper.
- Operands and op are accepted with a valid/ready handshake. The ALU core computes the result and NZCV flags, which then travel through a configurable number of result stages.
- Full-throughput streaming with backpressure, for datapath timing closure and as a streaming compute unit.

---
 rtl/alu_pipe.sv | 152 +++++++++++++++
 tb/tb_alu_pipe.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// Elastic pipelined ALU: one operand stage followed by LAT-1 result stages with valid/ready flow control.
// Optional signed saturating ADDS/SUBS (ops 8/9) enabled by defining ALU_PIPE_SAT_EN.
module alu_pipe #(
  parameter int N   = 4,
  parameter int LAT = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic [3:0]   op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] Y,
  output logic [3:0]   flags,
  output logic         busy
);

  localparam int RS = LAT - 1;

  logic [LAT-1:0] r_valid;
  logic [LAT-1:0] w_move;
  logic [LAT-1:0] w_load;

  logic [N-1:0]   r_a;
  logic [N-1:0]   r_b;
  logic [3:0]     r_op;
  logic [N-1:0]   r_y [RS];
  logic [3:0]     r_f [RS];

  logic [N:0]     w_sum;
  logic [N:0]     w_diff;
  logic           w_add_ovf;
  logic           w_sub_ovf;
  logic [N-1:0]   w_y;
  logic           w_c;
  logic           w_v;
  logic [3:0]     w_f;

  // A full stage moves if any stage downstream of it has a hole or the output drains;
  // this is the flattened form of the ready chain and avoids a self-referencing vector.
  genvar gi;
  generate
    for (gi = 0; gi < LAT; gi++) begin : g_move
      if (gi == LAT - 1) begin : g_last
        assign w_move[gi] = r_valid[gi] & out_ready;
      end else begin : g_mid
        assign w_move[gi] = r_valid[gi] & (out_ready | ~(&r_valid[LAT-1:gi+1]));
      end
    end
  endgenerate

  assign in_ready = ~r_valid[0] | w_move[0];
  assign w_load   = {w_move[LAT-2:0], in_valid & in_ready};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
    end else begin
      r_valid <= (r_valid & ~w_move) | w_load;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a  <= '0;
      r_b  <= '0;
      r_op <= '0;
    end else if (w_load[0]) begin
      r_a  <= A;
      r_b  <= B;
      r_op <= op;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < RS; k++) begin
        r_y[k] <= '0;
        r_f[k] <= '0;
      end
    end else begin
      if (w_load[1]) begin
        r_y[0] <= w_y;
        r_f[0] <= w_f;
      end
      for (int k = 1; k < RS; k++) begin
        if (w_load[k+1]) begin
          r_y[k] <= r_y[k-1];
          r_f[k] <= r_f[k-1];
        end
      end
    end
  end

  assign w_sum     = {1'b0, r_a} + {1'b0, r_b};
  assign w_diff    = {1'b0, r_a} - {1'b0, r_b};
  assign w_add_ovf = (r_a[N-1] == r_b[N-1]) && (w_sum[N-1] != r_a[N-1]);
  assign w_sub_ovf = (r_a[N-1] != r_b[N-1]) && (w_diff[N-1] != r_a[N-1]);

`ifdef ALU_PIPE_SAT_EN
  localparam logic [N-1:0] SAT_MAX = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] SAT_MIN = {1'b1, {(N-1){1'b0}}};
`endif

  // Native shift operators already yield 0 (SHL/SHR) or sign fill (SRA) for amounts >= N.
  always_comb begin
    w_y = '0;
    w_c = 1'b0;
    w_v = 1'b0;
    case (r_op)
      4'd0: begin
        w_y = w_sum[N-1:0];
        w_c = w_sum[N];
        w_v = w_add_ovf;
      end
      4'd1: begin
        w_y = w_diff[N-1:0];
        w_c = ~w_diff[N];
        w_v = w_sub_ovf;
      end
      4'd2: w_y = r_a & r_b;
      4'd3: w_y = r_a | r_b;
      4'd4: w_y = r_a ^ r_b;
      4'd5: w_y = r_a << r_b;
      4'd6: w_y = r_a >> r_b;
      4'd7: w_y = $signed(r_a) >>> r_b;
`ifdef ALU_PIPE_SAT_EN
      // Overflow direction follows A's sign for both saturating ops.
      4'd8: begin
        w_y = w_add_ovf ? (r_a[N-1] ? SAT_MIN : SAT_MAX) : w_sum[N-1:0];
        w_v = w_add_ovf;
      end
      4'd9: begin
        w_y = w_sub_ovf ? (r_a[N-1] ? SAT_MIN : SAT_MAX) : w_diff[N-1:0];
        w_v = w_sub_ovf;
      end
`endif
      default: ;
    endcase
  end

  assign w_f = {w_y[N-1], (w_y == '0), w_c, w_v};

  assign out_valid = r_valid[LAT-1];
  assign Y         = r_y[RS-1];
  assign flags     = r_f[RS-1];
  assign busy      = |r_valid;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed self-checking bench for alu_pipe (N=4, LAT=2); honours ALU_PIPE_SAT_EN when defined.
module tb_alu_pipe;
  localparam int N   = 4;
  localparam int LAT = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic [3:0]   op;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] Y;
  logic [3:0]   flags;
  logic         busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_pipe #(.N(N), .LAT(LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Y         (Y),
    .flags     (flags),
    .busy      (busy)
  );

  // Issue one op into an idle pipe and return the result plus edges from accept to out_valid.
  task automatic run_op(input logic [3:0] o, input logic [N-1:0] a, input logic [N-1:0] b,
                        output logic [N-1:0] y, output logic [3:0] f, output int lat);
    @(negedge clk);
    in_valid  = 1'b1;
    op        = o;
    A         = a;
    B         = b;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    @(negedge clk);
    while (!out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    y = Y;
    f = flags;
    $display("op=%0d A=%0d B=%0d -> Y=%0d flags=%b lat=%0d", o, a, b, y, f, lat);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    A         = '0;
    B         = '0;
    op        = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    $display("reset: out_valid=%0b Y=%0d flags=%b busy=%0b in_ready=%0b", out_valid, Y, flags, busy, in_ready);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++; if (Y !== 4'd0) begin errors++; $display("FAIL reset_Y got=%0d want=0", Y); end
    checks++; if (flags !== 4'b0000) begin errors++; $display("FAIL reset_flags got=%b want=0000", flags); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_arith;
    logic [3:0]   vo [6] = '{4'd0, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
    logic [N-1:0] va [6] = '{4'd7, 4'd15, 4'd3, 4'd12, 4'd12, 4'd12};
    logic [N-1:0] vb [6] = '{4'd1, 4'd1, 4'd5, 4'd10, 4'd10, 4'd10};
    logic [N-1:0] ey [6] = '{4'd8, 4'd0, 4'd14, 4'd8, 4'd14, 4'd6};
    logic [3:0]   ef [6] = '{4'b1001, 4'b0110, 4'b1000, 4'b1000, 4'b1000, 4'b0000};
    logic [N-1:0] y;
    logic [3:0]   f;
    int           lat;
    for (int i = 0; i < 6; i++) begin
      run_op(vo[i], va[i], vb[i], y, f, lat);
      checks++; if (lat !== LAT - 1) begin errors++; $display("FAIL arith%0d_latency got=%0d want=%0d", i, lat, LAT - 1); end
      checks++; if (y !== ey[i]) begin errors++; $display("FAIL arith%0d_Y got=%0d want=%0d", i, y, ey[i]); end
      checks++; if (f !== ef[i]) begin errors++; $display("FAIL arith%0d_flags got=%b want=%b", i, f, ef[i]); end
    end
  endtask

  task automatic test_shifts;
    logic [3:0]   vo [5] = '{4'd5, 4'd7, 4'd7, 4'd6, 4'd5};
    logic [N-1:0] va [5] = '{4'd3, 4'd9, 4'd9, 4'd9, 4'd3};
    logic [N-1:0] vb [5] = '{4'd5, 4'd1, 4'd7, 4'd1, 4'd2};
    logic [N-1:0] ey [5] = '{4'd0, 4'd12, 4'd15, 4'd4, 4'd12};
    logic [3:0]   ef [5] = '{4'b0100, 4'b1000, 4'b1000, 4'b0000, 4'b1000};
    logic [N-1:0] y;
    logic [3:0]   f;
    int           lat;
    for (int i = 0; i < 5; i++) begin
      run_op(vo[i], va[i], vb[i], y, f, lat);
      checks++; if (y !== ey[i]) begin errors++; $display("FAIL shift%0d_Y got=%0d want=%0d", i, y, ey[i]); end
      checks++; if (f !== ef[i]) begin errors++; $display("FAIL shift%0d_flags got=%b want=%b", i, f, ef[i]); end
    end
  endtask

  task automatic test_ext_ops;
`ifdef ALU_PIPE_SAT_EN
    logic [3:0]   vo [3] = '{4'd8, 4'd9, 4'd10};
    logic [N-1:0] va [3] = '{4'd7, 4'd8, 4'd5};
    logic [N-1:0] vb [3] = '{4'd1, 4'd1, 4'd3};
    logic [N-1:0] ey [3] = '{4'd7, 4'd8, 4'd0};
    logic [3:0]   ef [3] = '{4'b0001, 4'b1001, 4'b0100};
`else
    logic [3:0]   vo [3] = '{4'd8, 4'd9, 4'd15};
    logic [N-1:0] va [3] = '{4'd7, 4'd8, 4'd5};
    logic [N-1:0] vb [3] = '{4'd1, 4'd1, 4'd3};
    logic [N-1:0] ey [3] = '{4'd0, 4'd0, 4'd0};
    logic [3:0]   ef [3] = '{4'b0100, 4'b0100, 4'b0100};
`endif
    logic [N-1:0] y;
    logic [3:0]   f;
    int           lat;
    for (int i = 0; i < 3; i++) begin
      run_op(vo[i], va[i], vb[i], y, f, lat);
      checks++; if (lat !== LAT - 1) begin errors++; $display("FAIL ext%0d_latency got=%0d want=%0d", i, lat, LAT - 1); end
      checks++; if (y !== ey[i]) begin errors++; $display("FAIL ext%0d_Y got=%0d want=%0d", i, y, ey[i]); end
      checks++; if (f !== ef[i]) begin errors++; $display("FAIL ext%0d_flags got=%b want=%b", i, f, ef[i]); end
    end
  endtask

  task automatic test_backpressure;
    int           idx = 0;
    int           got = 0;
    logic [N-1:0] got_y [4] = '{4'd0, 4'd0, 4'd0, 4'd0};
    logic [N-1:0] exp_y [4] = '{4'd2, 4'd4, 4'd6, 4'd8};
    logic         in_x;
    logic         out_x;
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge clk);
      in_valid  = (idx < 4);
      A         = 4'(idx + 1);
      B         = 4'(idx + 1);
      op        = 4'd0;
      out_ready = 1'b0;
      #1;
      in_x = in_valid && in_ready;
      $display("stall cyc=%0d in_ready=%0b out_valid=%0b Y=%0d held=%0d", cyc, in_ready, out_valid, Y, idx);
      if (cyc >= 2) begin
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_full cyc=%0d got=%b want=0", cyc, in_ready); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid_stall cyc=%0d got=%b want=1", cyc, out_valid); end
        checks++; if (Y !== 4'd2) begin errors++; $display("FAIL bp_Y_stable cyc=%0d got=%0d want=2", cyc, Y); end
      end
      @(posedge clk);
      if (in_x) idx++;
    end
    checks++; if (idx !== LAT) begin errors++; $display("FAIL bp_capacity got=%0d want=%0d", idx, LAT); end
    for (int cyc = 0; cyc < 20 && got < 4; cyc++) begin
      @(negedge clk);
      in_valid  = (idx < 4);
      A         = 4'(idx + 1);
      B         = 4'(idx + 1);
      out_ready = 1'b1;
      #1;
      if (cyc == 0) begin
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_no_bubble got=%b want=1", in_ready); end
      end
      in_x  = in_valid && in_ready;
      out_x = out_valid && out_ready;
      if (out_x) begin
        got_y[got] = Y;
        got++;
        $display("drain out=%0d Y=%0d", got, Y);
      end
      @(posedge clk);
      if (in_x) idx++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++; if (got !== 4) begin errors++; $display("FAIL bp_count got=%0d want=4", got); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (got_y[i] !== exp_y[i]) begin errors++; $display("FAIL bp_order%0d got=%0d want=%0d", i, got_y[i], exp_y[i]); end
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_no_duplicate got=%b want=0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_idle_busy got=%b want=0", busy); end
  endtask

  task automatic test_reset_midstream;
    logic [N-1:0] y;
    logic [3:0]   f;
    int           lat;
    @(negedge clk);
    in_valid  = 1'b1;
    op        = 4'd0;
    A         = 4'd1;
    B         = 4'd1;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    A = 4'd2;
    B = 4'd2;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst_preload_busy got=%b want=1", busy); end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    $display("midrst: out_valid=%0b Y=%0d flags=%b busy=%0b", out_valid, Y, flags, busy);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid got=%b want=0", out_valid); end
    checks++; if (Y !== 4'd0) begin errors++; $display("FAIL midrst_Y got=%0d want=0", Y); end
    checks++; if (flags !== 4'b0000) begin errors++; $display("FAIL midrst_flags got=%b want=0000", flags); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b want=0", busy); end
    run_op(4'd0, 4'd5, 4'd6, y, f, lat);
    checks++; if (lat !== LAT - 1) begin errors++; $display("FAIL midrst_next_latency got=%0d want=%0d", lat, LAT - 1); end
    checks++; if (y !== 4'd11) begin errors++; $display("FAIL midrst_next_Y got=%0d want=11", y); end
    checks++; if (f !== 4'b1001) begin errors++; $display("FAIL midrst_next_flags got=%b want=1001", f); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_no_stale got=%b want=0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_shifts();
    test_ext_ops();
    test_backpressure();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
